// File: rtl/err_detect_responder.sv
// Synchronous sample/error responder: synchronizes the 4-phase `sample` request and compares main vs shadow capture.
// It answers on a dual-rail, return-to-zero Err1/Err0 pair and keeps protocol and verdict statistics.
module err_detect_responder #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int RESP_DELAY  = 1,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample,
    input  logic [W-1:0]  main_data,
    input  logic [W-1:0]  shadow_data,
    input  logic          err_inject,
    output logic          Err1,
    output logic          Err0,
    output logic          busy,
    output logic          protocol_err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] sample_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EVAL,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sample_s;
    logic [3:0]             r_dly;
    logic                   r_mismatch;
    logic                   r_err1;
    logic                   r_err0;
    logic                   r_proto;
    logic [CW-1:0]          r_err_cnt;
    logic [CW-1:0]          r_smp_cnt;

    logic                   w_capture;
    logic                   w_verdict;
    logic                   w_rtz;
    logic                   w_withdraw;
    logic                   w_dec;

    assign w_sample_s = r_sync[SYNC_STAGES-1];

    // Withdrawal is tested before the delay counter so an early drop never yields a verdict.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_verdict   = 1'b0;
        w_rtz       = 1'b0;
        w_withdraw  = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sample_s) begin
                    w_state_nxt = S_EVAL;
                    w_capture   = 1'b1;
                end
            end
            S_EVAL: begin
                if (!w_sample_s) begin
                    w_state_nxt = S_IDLE;
                    w_withdraw  = 1'b1;
                end else if (r_dly == 4'd0) begin
                    w_state_nxt = S_RESP;
                    w_verdict   = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            S_RESP: begin
                if (!w_sample_s) begin
                    w_state_nxt = S_IDLE;
                    w_rtz       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync    <= '0;
            r_dly     <= 4'd0;
            r_err1    <= 1'b0;
            r_err0    <= 1'b0;
            r_proto   <= 1'b0;
            r_err_cnt <= '0;
            r_smp_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], sample};

            if (w_capture) begin
                r_dly <= 4'(RESP_DELAY);
            end else if (w_dec) begin
                r_dly <= r_dly - 4'd1;
            end

            if (w_verdict) begin
                r_err1    <= r_mismatch;
                r_err0    <= ~r_mismatch;
                r_smp_cnt <= r_smp_cnt + CW'(1);
                if (r_mismatch && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + CW'(1);
                end
            end else if (w_rtz) begin
                r_err1 <= 1'b0;
                r_err0 <= 1'b0;
            end

            if (w_withdraw) begin
                r_proto <= 1'b1;
            end
        end
    end

    // Only read after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_mismatch <= (main_data != shadow_data) | err_inject;
        end
    end

    assign Err1         = r_err1;
    assign Err0         = r_err0;
    assign busy         = (r_state != S_IDLE);
    assign protocol_err = r_proto;
    assign err_count    = r_err_cnt;
    assign sample_count = r_smp_cnt;

endmodule

// File: tb/tb_err_detect_responder.sv
// Directed bench for err_detect_responder: edge-accurate handshake timing, verdicts, withdrawal, saturation and reset.
module tb_err_detect_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample;
    logic [7:0] main_data;
    logic [7:0] shadow_data;
    logic       err_inject;
    logic       Err1, Err0, busy, protocol_err;
    logic [7:0] err_count, sample_count;

    logic       b_sample;
    logic [7:0] b_main, b_shadow;
    logic       b_err1, b_err0, b_busy, b_proto;
    logic [1:0] b_err_count, b_sample_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    err_detect_responder #(.W(8), .SYNC_STAGES(2), .RESP_DELAY(1), .CW(8)) dut (
        .clk(clk), .rst(rst), .sample(sample), .main_data(main_data),
        .shadow_data(shadow_data), .err_inject(err_inject),
        .Err1(Err1), .Err0(Err0), .busy(busy), .protocol_err(protocol_err),
        .err_count(err_count), .sample_count(sample_count)
    );

    err_detect_responder #(.W(8), .SYNC_STAGES(2), .RESP_DELAY(1), .CW(2)) dut_b (
        .clk(clk), .rst(rst), .sample(b_sample), .main_data(b_main),
        .shadow_data(b_shadow), .err_inject(1'b0),
        .Err1(b_err1), .Err0(b_err0), .busy(b_busy), .protocol_err(b_proto),
        .err_count(b_err_count), .sample_count(b_sample_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full handshake on the main instance; edge 1 is the first edge with sample high.
    task automatic handshake(input string tag, input logic [7:0] m, input logic [7:0] s,
                             input logic inj, input logic exp_err);
        main_data   = m;
        shadow_data = s;
        err_inject  = inj;
        sample      = 1'b1;
        tick(4);
        check({tag, "_rails_e4"}, {30'd0, Err1, Err0}, 32'd0);
        check({tag, "_busy_e4"}, {31'd0, busy}, 32'd1);
        tick(1);
        check({tag, "_rails_e5"}, {30'd0, Err1, Err0}, {30'd0, exp_err, ~exp_err});
        sample = 1'b0;
        tick(2);
        check({tag, "_hold_e2"}, {30'd0, Err1, Err0}, {30'd0, exp_err, ~exp_err});
        tick(1);
        check({tag, "_rtz_e3"}, {29'd0, Err1, Err0, busy}, 32'd0);
    endtask

    task automatic b_handshake;
        b_sample = 1'b1;
        tick(5);
        check("sat_err1", {30'd0, b_err1, b_err0}, 32'd2);
        b_sample = 1'b0;
        tick(3);
        check("sat_rtz", {30'd0, b_err1, b_err0}, 32'd0);
    endtask

    initial begin
        logic seen_rail;
        rst = 1'b1; sample = 1'b0; main_data = 8'h00; shadow_data = 8'h00; err_inject = 1'b0;
        b_sample = 1'b0; b_main = 8'h01; b_shadow = 8'h02;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_flags", {28'd0, Err1, Err0, busy, protocol_err}, 32'd0);
        check("reset_counts", {16'd0, err_count, sample_count}, 32'd0);

        // Match, no inject
        handshake("match", 8'hA5, 8'hA5, 1'b0, 1'b0);
        check("match_counts", {16'd0, err_count, sample_count}, {16'd0, 8'd0, 8'd1});

        // Single-bit mismatch
        handshake("mism", 8'hA5, 8'hA4, 1'b0, 1'b1);
        check("mism_counts", {16'd0, err_count, sample_count}, {16'd0, 8'd1, 8'd2});

        // Inject with data disturbed after capture
        main_data = 8'h3C; shadow_data = 8'h3C; err_inject = 1'b1; sample = 1'b1;
        tick(3);
        main_data = 8'h00; err_inject = 1'b0;
        tick(2);
        check("inject_e5", {30'd0, Err1, Err0}, 32'd2);
        sample = 1'b0;
        tick(3);
        check("inject_rtz", {29'd0, Err1, Err0, busy}, 32'd0);
        check("inject_counts", {16'd0, err_count, sample_count}, {16'd0, 8'd2, 8'd3});
        handshake("after_inj", 8'h3C, 8'h3C, 1'b0, 1'b0);
        check("after_inj_counts", {16'd0, err_count, sample_count}, {16'd0, 8'd2, 8'd4});

        // Early withdrawal: sample high for two edges only
        main_data = 8'h11; shadow_data = 8'h22; sample = 1'b1;
        seen_rail = 1'b0;
        tick(2);
        sample = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (Err1 || Err0) seen_rail = 1'b1;
        end
        check("wd_no_rail", {31'd0, seen_rail}, 32'd0);
        check("wd_proto", {30'd0, protocol_err, busy}, 32'd2);
        check("wd_counts", {16'd0, err_count, sample_count}, {16'd0, 8'd2, 8'd4});
        handshake("after_wd", 8'h11, 8'h22, 1'b0, 1'b1);
        check("after_wd_counts", {16'd0, err_count, sample_count}, {16'd0, 8'd3, 8'd5});
        check("proto_sticky", {31'd0, protocol_err}, 32'd1);

        // Saturation and wrap on the CW=2 instance
        for (int i = 0; i < 3; i++) b_handshake();
        check("sat3_counts", {28'd0, b_err_count, b_sample_count}, {28'd0, 2'd3, 2'd3});
        b_handshake();
        check("sat4_counts", {28'd0, b_err_count, b_sample_count}, {28'd0, 2'd3, 2'd0});
        b_handshake();
        check("sat5_counts", {28'd0, b_err_count, b_sample_count}, {28'd0, 2'd3, 2'd1});

        // Reset while holding Err1, sample kept high through release
        main_data = 8'hA5; shadow_data = 8'hA4; sample = 1'b1;
        tick(5);
        check("rr_pre", {30'd0, Err1, Err0}, 32'd2);
        rst = 1'b1;
        tick(1);
        check("rr_flags", {28'd0, Err1, Err0, busy, protocol_err}, 32'd0);
        check("rr_counts", {16'd0, err_count, sample_count}, 32'd0);
        check("rr_b_counts", {28'd0, b_err_count, b_sample_count}, 32'd0);
        rst = 1'b0;
        tick(4);
        check("rr_e4", {29'd0, Err1, Err0, busy}, 32'd1);
        tick(1);
        check("rr_e5", {30'd0, Err1, Err0}, 32'd2);
        check("rr_counts2", {16'd0, err_count, sample_count}, {16'd0, 8'd1, 8'd1});
        sample = 1'b0;
        tick(3);
        check("rr_rtz", {29'd0, Err1, Err0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/err_detect_responder.md
Name: err_detect_responder

Overview:
- Synchronous responder for the sample/error side of the timing-resilient stage controller.
- Receives the controller's 4-phase `sample` request and compares the stage's main capture register against its shadow register.
- Returns a dual-rail, return-to-zero verdict on Err1/Err0: Err1 = timing error, Err0 = no error.
- Replaces the behavioural error model in benches and sits beside the controller in each pipeline stage.

Parameters:
- W, 8, width of the main and shadow data compared.
- SYNC_STAGES, 2, flops in the `sample` synchronizer (minimum 2).
- RESP_DELAY, 1, extra clk cycles between the compare capture and the verdict (0..15).
- CW, 8, width of the statistics counters.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- sample  input  1  4-phase request from the controller, asynchronous to clk.
- main_data  input  W  main flop contents of the stage.
- shadow_data  input  W  shadow (delayed) latch contents of the stage.
- err_inject  input  1  forces an error verdict for the current request.
- Err1  output  1  dual-rail true rail: error detected.
- Err0  output  1  dual-rail false rail: no error.
- busy  output  1  high from request acceptance until return-to-zero completes.
- protocol_err  output  1  sticky flag: `sample` withdrawn before a verdict was issued.
- err_count  output  CW  number of Err1 verdicts, saturating.
- sample_count  output  CW  number of verdicts issued, wrapping.

Behaviour:
- Reset: rst high at a clk edge clears everything.
  - Outputs: Err1=0, Err0=0, busy=0, protocol_err=0, err_count=0, sample_count=0.
  - Internal: synchronizer flops cleared, state=IDLE, delay counter cleared.
  - Reset mid-handshake abandons the transaction; no verdict is emitted afterwards for it.
- Synchronizer: `sample` passes through SYNC_STAGES flops to give sample_s. Only sample_s is used internally.
- State machine:
  - IDLE: Err1=Err0=0, busy=0.
    - sample_s=1 → EVAL.
    - On that same edge: latch mismatch = (main_data != shadow_data) | err_inject; load delay counter with RESP_DELAY; busy=1.
  - EVAL:
    - sample_s=0 → IDLE; set protocol_err; no verdict; counters unchanged.
    - Otherwise, counter==0 → RESP, registering Err1=mismatch and Err0=~mismatch. sample_count+1. err_count+1 if mismatch, unless it is all ones (saturates).
    - Otherwise, decrement the counter.
  - RESP: hold the verdict while sample_s=1.
    - sample_s=0 → IDLE; Err1=Err0=0 and busy=0 on the same edge.
- Timing: count the first edge at which `sample` is high as edge 1.
  - Data are captured at edge SYNC_STAGES+1.
  - The verdict rail rises at edge SYNC_STAGES+2+RESP_DELAY.
  - After `sample` falls, the rail drops at edge SYNC_STAGES+1, counting the first edge where `sample` is low as edge 1.
- Invariants:
  - Err1 and Err0 are never both high.
  - The verdict never changes while in RESP.
  - A new request is accepted only from IDLE, i.e. only after a full return-to-zero.
- main_data/shadow_data/err_inject are sampled only at the IDLE→EVAL edge. Changes afterwards do not affect the pending verdict.
- protocol_err clears only on rst.
- sample_count wraps from all ones to 0.

Test Plan:
- Match, no inject: W=8, main=shadow=8'hA5, SYNC_STAGES=2, RESP_DELAY=1; raise `sample` → Err0 rises at edge 5 with Err1=0; drop `sample` → Err0 falls at edge 3; sample_count=1, err_count=0.
- Mismatch: main=8'hA5, shadow=8'hA4 → Err1=1 at edge 5, Err0=0; err_count=1; after RTZ both rails 0, busy=0.
- Inject plus data change after capture: main=shadow, err_inject=1 at capture, main changed to 8'h00 in EVAL → Err1=1; next request with err_inject=0 and equal data → Err0=1.
- Early withdrawal: `sample` high 2 cycles then low → no verdict rail ever rises, protocol_err=1, counters unchanged; the next full handshake works normally and protocol_err stays 1.
- Saturation/wrap: CW=2, 5 mismatching handshakes → err_count=3, sample_count=1.
- Reset in RESP: assert rst while Err1=1 → next edge Err1=Err0=0, all counters 0; with `sample` still high after rst drops, a new verdict is issued at edge SYNC_STAGES+2+RESP_DELAY after release.
